step_sequencer: RTL and testbench
=================================

STEP_SEQUENCER -- requirements
Module: step_sequencer

Interface
REQ-001 STEPS, 8, number of pattern entries; the step index width is clog2(STEPS).
REQ-002 INCWIDTH, 16, width of the phase increment driven to the oscillator.
REQ-003 clk  input  1  system clock; single clock domain.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 sample_clock  input  1  audio sample clock level from the sample counter; sampled in the clk domain.
REQ-006 run  input  1  level; high = play pattern, low = stop.
REQ-007 tempo  input  16  step length in sample ticks; 0 is treated as 1.
REQ-008 gate_len  input  16  gate-high length in sample ticks within a step.
REQ-009 last_step  input  clog2(STEPS)  index of the final step before wrap.
REQ-010 wr_en  input  1  pattern write strobe, one entry per clk.
REQ-011 wr_addr  input  clog2(STEPS)  pattern entry to write.
REQ-012 wr_inc  input  INCWIDTH  increment value to store.
REQ-013 wr_rest  input  1  rest flag to store; 1 = no gate on that step.
REQ-014 increment  output  INCWIDTH  registered increment to the oscillator.
REQ-015 gate  output  1  registered gate to the envelope.
REQ-016 step  output  clog2(STEPS)  index of the current step.
REQ-017 step_strobe  output  1  one-clk pulse at each step start.
REQ-018 running  output  1  high when state is not IDLE.

Function
REQ-019 tick = sample_clock & ~sample_clock_q, where sample_clock_q is sample_clock registered on clk; tick is exactly one clk per sample period.
REQ-020 The pattern is STEPS entries of {inc[INCWIDTH-1:0], rest}; a write with wr_en=1 updates entry wr_addr at the clk edge.
REQ-021 States: IDLE, GATE_ON, GATE_OFF.
REQ-022 The counter cnt (16 bit) counts ticks within the current step and increments only on tick.
REQ-023 IDLE with run=1 -> next edge: step=0, cnt=0, increment=pattern[0].inc, step_strobe=1, and state/gate set by the step-load rule (REQ-024).
REQ-024 Step-load rule: if rest=1 or gate_len=0 then gate=0 and the state is GATE_OFF; otherwise gate=1 and the state is GATE_ON.
REQ-025 GATE_ON, on a tick with cnt+1 == gate_len and cnt+1 < eff_tempo -> gate=0, state GATE_OFF; if gate_len >= eff_tempo, gate stays high for the whole step (legato).
REQ-026 On a tick with cnt+1 >= eff_tempo (eff_tempo = max(tempo,1)) in GATE_ON or GATE_OFF -> step end.
REQ-027 At step end: cnt=0, and step = (step >= last_step) ? 0 : step+1.
REQ-028 At step end: increment and the state/gate are loaded from the new entry per REQ-024, and step_strobe=1 for one clk.
REQ-029 Latency: gate and increment change on the same clk edge as step_strobe, which is one clk after the qualifying tick or run edge.
REQ-030 Step end takes priority over the gate-off transition on the same tick.
REQ-031 If a write hits the entry being loaded on the same edge, the load uses the pre-write value (read-before-write).
REQ-032 A write to the currently playing entry takes effect at that entry's next load.
REQ-033 Any state with run=0 -> next edge: IDLE, gate=0, increment=0, step=0, cnt=0, step_strobe=0; run=0 overrides a simultaneous tick.
REQ-034 Changes to tempo, gate_len or last_step mid-step apply to the comparisons on the next tick; a step beyond a reduced last_step wraps to 0 at its end.
REQ-035 step_strobe=0 on every clk other than a step start.

Reset
REQ-036 rst=1 at a clk edge forces IDLE, increment=0, gate=0, step=0, step_strobe=0, running=0, cnt=0, sample_clock_q=0.
REQ-037 rst=1 clears every pattern entry to inc=0, rest=1, and rst overrides wr_en and run.
REQ-038 rst asserted mid-step takes effect on that edge with no gate glitch; after release with run=1, play restarts at step 0 on the next edge.

Verification
REQ-039 Load entries 0..3 = {100,0},{200,0},{300,1},{400,0}; set last_step=3, tempo=4, gate_len=2, run=1 -> strobes every 4 ticks, step sequence 0,1,2,3,0, and gate high 2 ticks per step except low during step 2.
REQ-040 With tempo=3 and gate_len=5 -> gate stays continuously high across steps while increment updates on each strobe.
REQ-041 Drop run mid-step 1 -> the next clk gives gate=0, increment=0, step=0, running=0; raising run restarts at step 0 with increment=100.
REQ-042 Write entry 1 = {999,0} on the same edge that entry 1 loads -> increment=200 now, and 999 on the following pass.
REQ-043 At step 3, set last_step=1 -> the next step end wraps to 0; with tempo=0 the step advances every tick.
REQ-044 Assert rst for 1 clk during GATE_ON -> all outputs are at reset values and the pattern reads back rest=1 for all steps, so the gate stays 0 with run=1.

Source files
------------

// File: rtl/step_sequencer.sv
// Step sequencer: plays a STEPS-entry pattern of {increment, rest} pairs,
// advancing one step every `tempo` audio sample ticks and driving a gate
// that stays high for `gate_len` ticks of each non-rest step.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   IDLE     | stopped; outputs held at zero, waiting for run
//   GATE_ON  | step playing, gate high, waiting for gate-off or step end
//   GATE_OFF | step playing, gate low (rest or gate expired), waiting for step end
module step_sequencer #(
  parameter int STEPS    = 8,
  parameter int INCWIDTH = 16,
  localparam int SW      = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sample_clock,
  input  logic                run,
  input  logic [15:0]         tempo,
  input  logic [15:0]         gate_len,
  input  logic [SW-1:0]       last_step,
  input  logic                wr_en,
  input  logic [SW-1:0]       wr_addr,
  input  logic [INCWIDTH-1:0] wr_inc,
  input  logic                wr_rest,
  output logic [INCWIDTH-1:0] increment,
  output logic                gate,
  output logic [SW-1:0]       step,
  output logic                step_strobe,
  output logic                running
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] GATE_ON  = 2'd1;
  localparam logic [1:0] GATE_OFF = 2'd2;

  logic [1:0]          state;
  logic                sample_clock_q;
  logic [15:0]         cnt;
  logic [INCWIDTH-1:0] pat_inc  [STEPS];
  logic                pat_rest [STEPS];

  logic                tick;
  logic [15:0]         eff_tempo;
  logic [16:0]         cnt_next;
  logic                step_end;
  logic                gate_end;
  logic [SW-1:0]       next_step;
  logic [SW-1:0]       load_idx;
  logic                load_quiet;

  // One-clk tick on each rising edge of the sample clock level.
  assign tick      = sample_clock & ~sample_clock_q;
  // A zero tempo would never end a step, so it behaves as one tick per step.
  assign eff_tempo = (tempo == 16'd0) ? 16'd1 : tempo;
  // 17 bits so a full 16-bit count cannot wrap in the comparisons.
  assign cnt_next  = {1'b0, cnt} + 17'd1;
  assign step_end  = tick && (cnt_next >= {1'b0, eff_tempo});
  // Gate-off only when it lands strictly inside the step; otherwise legato.
  assign gate_end  = tick && (cnt_next == {1'b0, gate_len}) &&
                     (cnt_next < {1'b0, eff_tempo});
  // >= so a step stranded past a reduced last_step still wraps to 0.
  assign next_step = (step >= last_step) ? '0 : step + SW'(1);
  assign load_idx  = (state == IDLE) ? '0 : next_step;
  assign load_quiet = pat_rest[load_idx] | (gate_len == 16'd0);
  assign running   = (state != IDLE);

  // Pattern memory; the step load reads the old value on a colliding write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STEPS; i++) begin
        pat_inc[i]  <= '0;
        pat_rest[i] <= 1'b1;
      end
    end else if (wr_en) begin
      pat_inc[wr_addr]  <= wr_inc;
      pat_rest[wr_addr] <= wr_rest;
    end
  end

  // Sequencing FSM with registered outputs: start, step end, gate-off, stop.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      sample_clock_q <= 1'b0;
      cnt            <= '0;
      step           <= '0;
      increment      <= '0;
      gate           <= 1'b0;
      step_strobe    <= 1'b0;
    end else begin
      sample_clock_q <= sample_clock;
      step_strobe    <= 1'b0;
      if (!run) begin
        state     <= IDLE;
        cnt       <= '0;
        step      <= '0;
        increment <= '0;
        gate      <= 1'b0;
      end else if ((state == IDLE) || step_end) begin
        step        <= load_idx;
        cnt         <= '0;
        increment   <= pat_inc[load_idx];
        step_strobe <= 1'b1;
        if (load_quiet) begin
          gate  <= 1'b0;
          state <= GATE_OFF;
        end else begin
          gate  <= 1'b1;
          state <= GATE_ON;
        end
      end else if (tick) begin
        cnt <= cnt_next[15:0];
        if ((state == GATE_ON) && gate_end) begin
          gate  <= 1'b0;
          state <= GATE_OFF;
        end
      end
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: directed vector table, hand-written corner
// sequences, then randomized play checked against a tick-counting model.
module tb_step_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sc = 1'b0;
  logic        run = 1'b0;
  logic [15:0] tempo = 16'd4;
  logic [15:0] gate_len = 16'd2;
  logic [2:0]  last_step = 3'd3;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = 3'd0;
  logic [15:0] wr_inc = 16'd0;
  logic        wr_rest = 1'b0;
  logic [15:0] increment;
  logic        gate;
  logic [2:0]  step;
  logic        step_strobe;
  logic        running;

  int checks = 0;
  int errors = 0;

  step_sequencer #(.STEPS(8), .INCWIDTH(16)) dut (
    .clk(clk), .rst(rst), .sample_clock(sc), .run(run),
    .tempo(tempo), .gate_len(gate_len), .last_step(last_step),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_inc(wr_inc), .wr_rest(wr_rest),
    .increment(increment), .gate(gate), .step(step),
    .step_strobe(step_strobe), .running(running)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  // Reference model: counts elapsed ticks in the current step and derives the
  // gate from that count; pattern entries are snapshotted when a step loads.
  int m_pat_inc [8];
  bit m_pat_rest [8];
  int m_step, m_elapsed, m_inc;
  bit m_rest, m_strobe, m_playing, m_sc_q;

  function automatic void m_load(int idx);
    m_step    = idx;
    m_elapsed = 0;
    m_inc     = m_pat_inc[idx];
    m_rest    = m_pat_rest[idx];
    m_strobe  = 1'b1;
  endfunction

  function automatic int m_eff();
    return (tempo == 16'd0) ? 1 : int'(tempo);
  endfunction

  function automatic int m_gate();
    if (!m_playing || m_rest || gate_len == 16'd0) return 0;
    if (int'(gate_len) >= m_eff()) return 1;
    return (m_elapsed < int'(gate_len)) ? 1 : 0;
  endfunction

  task automatic model_step();
    bit tk;
    tk = sc && !m_sc_q;
    if (rst) begin
      m_playing = 0; m_step = 0; m_elapsed = 0; m_inc = 0;
      m_rest = 1; m_strobe = 0; m_sc_q = 0;
      for (int i = 0; i < 8; i++) begin
        m_pat_inc[i]  = 0;
        m_pat_rest[i] = 1;
      end
      return;
    end
    m_strobe = 0;
    if (!run) begin
      m_playing = 0; m_step = 0; m_elapsed = 0; m_inc = 0; m_rest = 1;
    end else if (!m_playing) begin
      m_playing = 1;
      m_load(0);
    end else if (tk) begin
      m_elapsed++;
      if (m_elapsed >= m_eff())
        m_load((m_step >= int'(last_step)) ? 0 : m_step + 1);
    end
    if (wr_en) begin
      m_pat_inc[wr_addr]  = int'(wr_inc);
      m_pat_rest[wr_addr] = wr_rest;
    end
    m_sc_q = sc;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model, then compare every output to it.
  task automatic do_clk();
    @(posedge clk);
    model_step();
    #1;
    chk("model_step", int'(step), m_step);
    chk("model_inc", int'(increment), m_inc);
    chk("model_gate", int'(gate), m_gate());
    chk("model_strobe", int'(step_strobe), int'(m_strobe));
    chk("model_running", int'(running), int'(m_playing));
  endtask

  task automatic do_tick();
    sc = 1'b1; do_clk();
    sc = 1'b0; do_clk();
  endtask

  task automatic write_entry(int a, int v, bit r);
    wr_en = 1'b1; wr_addr = 3'(a); wr_inc = 16'(v); wr_rest = r;
    do_clk();
    wr_en = 1'b0;
  endtask

  typedef struct {
    int run; int tk;
    int exp_step; int exp_gate; int exp_inc; int exp_strobe; int exp_running;
  } vec_t;
  vec_t vecs[$];

  task automatic add(int r, int t, int s, int g, int i, int st, int rn);
    vec_t v;
    v.run = r; v.tk = t; v.exp_step = s; v.exp_gate = g;
    v.exp_inc = i; v.exp_strobe = st; v.exp_running = rn;
    vecs.push_back(v);
  endtask

  int low_cnt, strobe_cnt, hi_cnt;

  initial begin
    // basic pattern play (tempo 4, gate 2, last 3), then stop/restart
    add(1,0, 0,1,100,1,1);
    add(1,1, 0,1,100,0,1); add(1,1, 0,0,100,0,1); add(1,1, 0,0,100,0,1);
    add(1,1, 1,1,200,1,1);
    add(1,1, 1,1,200,0,1); add(1,1, 1,0,200,0,1); add(1,1, 1,0,200,0,1);
    add(1,1, 2,0,300,1,1);
    add(1,1, 2,0,300,0,1); add(1,1, 2,0,300,0,1); add(1,1, 2,0,300,0,1);
    add(1,1, 3,1,400,1,1);
    add(1,1, 3,1,400,0,1); add(1,1, 3,0,400,0,1); add(1,1, 3,0,400,0,1);
    add(1,1, 0,1,100,1,1);
    add(1,1, 0,1,100,0,1); add(1,1, 0,0,100,0,1); add(1,1, 0,0,100,0,1);
    add(1,1, 1,1,200,1,1);
    add(1,1, 1,1,200,0,1);
    add(0,1, 0,0,0,0,0);
    add(1,0, 0,1,100,1,1);

    // reset
    do_clk(); do_clk();
    chk("reset_step", int'(step), 0);
    chk("reset_inc", int'(increment), 0);
    chk("reset_gate", int'(gate), 0);
    chk("reset_strobe", int'(step_strobe), 0);
    chk("reset_running", int'(running), 0);
    rst = 1'b0;
    do_clk();

    write_entry(0, 100, 0);
    write_entry(1, 200, 0);
    write_entry(2, 300, 1);
    write_entry(3, 400, 0);

    foreach (vecs[i]) begin
      run = vecs[i].run[0];
      sc  = vecs[i].tk[0];
      do_clk();
      chk("vec_step", int'(step), vecs[i].exp_step);
      chk("vec_gate", int'(gate), vecs[i].exp_gate);
      chk("vec_inc", int'(increment), vecs[i].exp_inc);
      chk("vec_strobe", int'(step_strobe), vecs[i].exp_strobe);
      chk("vec_running", int'(running), vecs[i].exp_running);
      sc = 1'b0;
      do_clk();
    end

    // legato: gate_len >= tempo keeps the gate high across steps
    run = 1'b0; do_clk();
    tempo = 16'd3; gate_len = 16'd5; last_step = 3'd1;
    run = 1'b1; do_clk();
    chk("legato_start_strobe", int'(step_strobe), 1);
    chk("legato_start_gate", int'(gate), 1);
    low_cnt = 0; strobe_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      sc = 1'b1; do_clk();
      if (gate !== 1'b1) low_cnt++;
      if (step_strobe) begin
        strobe_cnt++;
        chk("legato_inc", int'(increment), (step == 3'd0) ? 100 : 200);
      end
      sc = 1'b0; do_clk();
      if (gate !== 1'b1) low_cnt++;
    end
    chk("legato_gate_low_cycles", low_cnt, 0);
    chk("legato_strobes", strobe_cnt, 4);

    // write to entry 1 on the edge that loads it: old value now, new next pass
    run = 1'b0; do_clk();
    tempo = 16'd2; gate_len = 16'd1; last_step = 3'd1;
    run = 1'b1; do_clk();
    do_tick();
    sc = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_inc = 16'd999; wr_rest = 1'b0;
    do_clk();
    chk("rbw_step", int'(step), 1);
    chk("rbw_inc_old", int'(increment), 200);
    chk("rbw_strobe", int'(step_strobe), 1);
    wr_en = 1'b0; sc = 1'b0; do_clk();
    do_tick(); do_tick();
    chk("rbw_wrap_step", int'(step), 0);
    chk("rbw_wrap_inc", int'(increment), 100);
    do_tick(); do_tick();
    chk("rbw_new_step", int'(step), 1);
    chk("rbw_inc_new", int'(increment), 999);

    // tempo 0 advances every tick; last_step reduced while at step 3
    run = 1'b0; do_clk();
    tempo = 16'd0; gate_len = 16'd1; last_step = 3'd3;
    run = 1'b1; do_clk();
    chk("t0_start_step", int'(step), 0);
    do_tick(); chk("t0_step1", int'(step), 1);
    do_tick(); chk("t0_step2", int'(step), 2);
    do_tick(); chk("t0_step3", int'(step), 3);
    last_step = 3'd1;
    do_tick(); chk("shrink_wrap_step", int'(step), 0);
    do_tick(); chk("shrink_step1", int'(step), 1);
    do_tick(); chk("shrink_wrap2_step", int'(step), 0);

    // reset during GATE_ON clears outputs and pattern (all rests)
    run = 1'b0; do_clk();
    tempo = 16'd4; gate_len = 16'd2; last_step = 3'd3;
    run = 1'b1; do_clk();
    chk("rst_pre_gate", int'(gate), 1);
    rst = 1'b1; do_clk();
    chk("rst_mid_gate", int'(gate), 0);
    chk("rst_mid_inc", int'(increment), 0);
    chk("rst_mid_step", int'(step), 0);
    chk("rst_mid_running", int'(running), 0);
    chk("rst_mid_strobe", int'(step_strobe), 0);
    rst = 1'b0; do_clk();
    chk("rst_restart_strobe", int'(step_strobe), 1);
    chk("rst_restart_step", int'(step), 0);
    chk("rst_restart_inc", int'(increment), 0);
    hi_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      do_tick();
      if (gate !== 1'b0) hi_cnt++;
    end
    chk("rst_pattern_rest_gate_high", hi_cnt, 0);

    // randomized play against the model
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      if (run) begin
        if ($urandom_range(0, 59) == 0) run = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        run = 1'b1;
      end
      if (!run) begin
        tempo    = 16'($urandom_range(0, 6));
        gate_len = 16'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 99) == 0) last_step = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) == 0) sc = ~sc;
      wr_en   = ($urandom_range(0, 3) == 0);
      wr_addr = 3'($urandom_range(0, 7));
      wr_inc  = 16'($urandom_range(0, 65535));
      wr_rest = ($urandom_range(0, 3) == 0);
      do_clk();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
